// File: rtl/draw_pkg.sv
// rtl/draw_pkg.sv - shared states, colours and geometry defaults for the cell renderer
package draw_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRAW    = 2'd1,
        DONE    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [2:0] COLOR_BG   = 3'b000;
    localparam logic [2:0] COLOR_X    = 3'b100;
    localparam logic [2:0] COLOR_O    = 3'b001;
    localparam logic [2:0] COLOR_GRID = 3'b111;

    localparam int CELL_SIZE_DEF = 32;
    localparam int MARGIN_DEF    = 4;

endpackage

// File: rtl/cell_renderer_if.sv
// rtl/cell_renderer_if.sv - draw request in, framebuffer write port and handshake out
interface cell_renderer_if #(
    parameter int X_W = 10,
    parameter int Y_W = 9
);
    logic           start;
    logic [1:0]     cell_row;
    logic [1:0]     cell_col;
    logic           player;
    logic [X_W-1:0] pixel_x;
    logic [Y_W-1:0] pixel_y;
    logic [2:0]     pixel_color;
    logic           pixel_write;
    logic           busy;
    logic           drawing_done;

    modport master (
        output start, cell_row, cell_col, player,
        input  pixel_x, pixel_y, pixel_color, pixel_write, busy, drawing_done
    );

    modport slave (
        input  start, cell_row, cell_col, player,
        output pixel_x, pixel_y, pixel_color, pixel_write, busy, drawing_done
    );
endinterface

// File: rtl/cell_pixel_shader.sv
// rtl/cell_pixel_shader.sv - maps a cell-local pixel to its colour
// GRID_LINES_EN: paint the outer ring of the cell white over any symbol.
module cell_pixel_shader
    import draw_pkg::*;
#(
    parameter  int CELL_SIZE = CELL_SIZE_DEF,
    parameter  int MARGIN    = MARGIN_DEF,
    localparam int DW        = $clog2(CELL_SIZE)
) (
    input  logic [DW-1:0] i_dx,
    input  logic [DW-1:0] i_dy,
    input  logic          i_player,
    output logic [2:0]    o_color
);
    localparam logic [DW-1:0] LO   = DW'(MARGIN);
    localparam logic [DW-1:0] HI   = DW'(CELL_SIZE - 1 - MARGIN);
    localparam logic [DW-1:0] LAST = DW'(CELL_SIZE - 1);

    logic w_inner;
    logic w_diag;
    logic w_ring;

    assign w_inner = (i_dx >= LO) && (i_dx <= HI) && (i_dy >= LO) && (i_dy <= HI);
    assign w_diag  = (i_dx == i_dy) || (({1'b0, i_dx} + {1'b0, i_dy}) == {1'b0, LAST});
    assign w_ring  = (i_dx == LO) || (i_dx == HI) || (i_dy == LO) || (i_dy == HI);

    always_comb begin
        o_color = COLOR_BG;
        if (w_inner) begin
            if (!i_player && w_diag) begin
                o_color = COLOR_X;
            end else if (i_player && w_ring) begin
                o_color = COLOR_O;
            end
        end
`ifdef GRID_LINES_EN
        if ((i_dx == '0) || (i_dy == '0) || (i_dx == LAST) || (i_dy == LAST)) begin
            o_color = COLOR_GRID;
        end
`else
        o_color = o_color;
`endif
    end
endmodule

// File: rtl/cell_renderer.sv
// rtl/cell_renderer.sv - raster-scans one board cell into the framebuffer per draw request
// GRID_LINES_EN (in cell_pixel_shader): white cell border over the symbol.
module cell_renderer
    import draw_pkg::*;
#(
    parameter int CELL_SIZE = CELL_SIZE_DEF,
    parameter int MARGIN    = MARGIN_DEF,
    parameter int GRID_X0   = 0,
    parameter int GRID_Y0   = 0,
    parameter int X_W       = 10,
    parameter int Y_W       = 9
) (
    input  logic            clock,
    input  logic            reset_n,
    cell_renderer_if.slave  bus
);
    localparam int            DW   = $clog2(CELL_SIZE);
    localparam logic [DW-1:0] LAST = DW'(CELL_SIZE - 1);

    state_t         r_state, w_state_nxt;
    logic [DW-1:0]  r_dx, r_dy, w_dx_nxt, w_dy_nxt;
    logic [1:0]     r_row, r_col, w_row_nxt, w_col_nxt;
    logic           r_player, w_player_nxt;
    logic           w_write_nxt, w_done_nxt;
    logic [X_W-1:0] w_x_nxt, r_pixel_x;
    logic [Y_W-1:0] w_y_nxt, r_pixel_y;
    logic [2:0]     w_color_nxt, r_pixel_color;
    logic           r_pixel_write, r_busy, r_done;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // Outputs are computed from the next scan position so they register alongside it.
    always_comb begin
        w_state_nxt  = r_state;
        w_dx_nxt     = r_dx;
        w_dy_nxt     = r_dy;
        w_row_nxt    = r_row;
        w_col_nxt    = r_col;
        w_player_nxt = r_player;
        w_write_nxt  = 1'b0;
        w_done_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_row_nxt    = bus.cell_row;
                    w_col_nxt    = bus.cell_col;
                    w_player_nxt = bus.player;
                    w_dx_nxt     = '0;
                    w_dy_nxt     = '0;
                    if ((bus.cell_row <= 2'd2) && (bus.cell_col <= 2'd2)) begin
                        w_state_nxt = DRAW;
                        w_write_nxt = 1'b1;
                    end else begin
                        w_state_nxt = DONE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            DRAW: begin
                if ((r_dx == LAST) && (r_dy == LAST)) begin
                    w_state_nxt = DONE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_write_nxt = 1'b1;
                    w_dx_nxt    = r_dx + 1'b1;
                    if (r_dx == LAST) w_dy_nxt = r_dy + 1'b1;
                end
            end
            DONE:    w_state_nxt = RELEASE;
            RELEASE: if (!bus.start) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_x_nxt = X_W'(GRID_X0) + X_W'(w_col_nxt) * X_W'(CELL_SIZE) + X_W'(w_dx_nxt);
    assign w_y_nxt = Y_W'(GRID_Y0) + Y_W'(w_row_nxt) * Y_W'(CELL_SIZE) + Y_W'(w_dy_nxt);

    cell_pixel_shader #(
        .CELL_SIZE (CELL_SIZE),
        .MARGIN    (MARGIN)
    ) u_shader (
        .i_dx     (w_dx_nxt),
        .i_dy     (w_dy_nxt),
        .i_player (w_player_nxt),
        .o_color  (w_color_nxt)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_dx          <= '0;
            r_dy          <= '0;
            r_row         <= '0;
            r_col         <= '0;
            r_player      <= 1'b0;
            r_pixel_x     <= '0;
            r_pixel_y     <= '0;
            r_pixel_color <= '0;
            r_pixel_write <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_dx          <= w_dx_nxt;
            r_dy          <= w_dy_nxt;
            r_row         <= w_row_nxt;
            r_col         <= w_col_nxt;
            r_player      <= w_player_nxt;
            r_pixel_x     <= w_write_nxt ? w_x_nxt : '0;
            r_pixel_y     <= w_write_nxt ? w_y_nxt : '0;
            r_pixel_color <= w_write_nxt ? w_color_nxt : COLOR_BG;
            r_pixel_write <= w_write_nxt;
            r_busy        <= (w_state_nxt != IDLE);
            r_done        <= w_done_nxt;
        end
    end

    assign bus.pixel_x      = r_pixel_x;
    assign bus.pixel_y      = r_pixel_y;
    assign bus.pixel_color  = r_pixel_color;
    assign bus.pixel_write  = r_pixel_write;
    assign bus.busy         = r_busy;
    assign bus.drawing_done = r_done;
endmodule

// File: tb/tb_cell_renderer.sv
// tb/tb_cell_renderer.sv - directed draws checked against a timeline model of the renderer
module tb_cell_renderer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cell_renderer_if #(.X_W(10), .Y_W(9)) bus ();

    cell_renderer #(
        .CELL_SIZE (32),
        .MARGIN    (4),
        .GRID_X0   (0),
        .GRID_Y0   (0),
        .X_W       (10),
        .Y_W       (9)
    ) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;
    int n = 0;
    bit m_busy = 0;
    bit m_valid = 0;
    bit m_player = 0;
    int m_k = 0;
    int m_row = 0;
    int m_col = 0;
    int wr_cnt = 0, done_cnt = 0, oob_cnt = 0, done_n = 0;
    int first_x = 0, first_y = 0, last_x = 0, last_y = 0;
    logic [2:0] fb [0:127][0:127];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [2:0] exp_color(input int dx, input int dy, input bit p);
        bit inner;
`ifdef GRID_LINES_EN
        if (dx == 0 || dy == 0 || dx == 31 || dy == 31) return 3'b111;
`endif
        inner = (dx >= 4) && (dx <= 27) && (dy >= 4) && (dy <= 27);
        if (!inner) return 3'b000;
        if (!p) return (dx == dy || dx + dy == 31) ? 3'b100 : 3'b000;
        return (dx == 4 || dx == 27 || dy == 4 || dy == 27) ? 3'b001 : 3'b000;
    endfunction

    // Timeline model: a draw accepted at edge k writes after edges k..k+1023, done after k+1024.
    always @(posedge clk) begin
        n = n + 1;
        if (!rst_n) begin
            m_busy = 0;
        end else if (!m_busy) begin
            if (bus.start === 1'b1) begin
                m_busy   = 1;
                m_k      = n;
                m_row    = int'(bus.cell_row);
                m_col    = int'(bus.cell_col);
                m_player = bus.player;
                m_valid  = (m_row <= 2) && (m_col <= 2);
            end
        end else if (n > (m_valid ? m_k + 1025 : m_k + 1) && bus.start === 1'b0) begin
            m_busy = 0;
        end
    end

    always @(negedge clk) begin
        int d, dx, dy, ew, ed, eb, ex, ey, ax, ay;
        logic [2:0] ec;
        logic [24:0] act_v, exp_v;
        ew = 0; ed = 0; eb = 0; ex = 0; ey = 0; ec = 3'b000;
        if (rst_n && m_busy) begin
            eb = 1;
            d  = n - m_k;
            if (m_valid && d < 1024) begin
                ew = 1;
                dx = d % 32;
                dy = d / 32;
                ex = m_col * 32 + dx;
                ey = m_row * 32 + dy;
                ec = exp_color(dx, dy, m_player);
            end
            ed = m_valid ? int'(d == 1024) : int'(d == 0);
        end
        act_v = {bus.pixel_write, bus.drawing_done, bus.busy, bus.pixel_color, bus.pixel_x, bus.pixel_y};
        exp_v = {1'(ew), 1'(ed), 1'(eb), ec, 10'(ex), 9'(ey)};
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL outputs edge %0d: got w=%0b d=%0b b=%0b c=%b x=%0d y=%0d expected w=%0d d=%0d b=%0d c=%b x=%0d y=%0d",
                     n, bus.pixel_write, bus.drawing_done, bus.busy, bus.pixel_color, bus.pixel_x, bus.pixel_y,
                     ew, ed, eb, ec, ex, ey);
        end
        if (bus.pixel_write === 1'b1) begin
            ax = int'(bus.pixel_x);
            ay = int'(bus.pixel_y);
            if (wr_cnt == 0) begin
                first_x = ax;
                first_y = ay;
            end
            last_x = ax;
            last_y = ay;
            wr_cnt++;
            if (ax < 128 && ay < 128) fb[ax][ay] = bus.pixel_color;
            if (ax > 31 || ay > 31) oob_cnt++;
        end
        if (bus.drawing_done === 1'b1) begin
            done_cnt++;
            done_n = n;
        end
    end

    task automatic cyc(input int k);
        repeat (k) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clear_stats();
        wr_cnt = 0;
        done_cnt = 0;
        oob_cnt = 0;
        for (int x = 0; x < 128; x++)
            for (int y = 0; y < 128; y++)
                fb[x][y] = 3'b010;
    endtask

    task automatic start_draw(input int r, input int c, input bit p);
        bus.cell_row = 2'(r);
        bus.cell_col = 2'(c);
        bus.player   = p;
        bus.start    = 1'b1;
    endtask

    task automatic wait_done(input string name, input int limit);
        int i = 0;
        while (done_cnt == 0 && i < limit) begin
            cyc(1);
            i++;
        end
        chk({name, " done pulses"}, done_cnt, 1);
    endtask

    initial begin
        int grid_c;
        int i;
`ifdef GRID_LINES_EN
        grid_c = 7;
`else
        grid_c = 0;
`endif
        bus.start = 1'b0;
        bus.cell_row = 2'd0;
        bus.cell_col = 2'd0;
        bus.player = 1'b0;
        clear_stats();
        cyc(3);
        chk("reset pixel_write", int'(bus.pixel_write), 0);
        chk("reset busy", int'(bus.busy), 0);
        chk("reset done", int'(bus.drawing_done), 0);
        chk("reset pixel_x", int'(bus.pixel_x), 0);
        rst_n = 1'b1;
        cyc(2);

        clear_stats();
        start_draw(1, 2, 0);
        wait_done("x draw", 1200);
        bus.start = 1'b0;
        cyc(3);
        chk("x writes", wr_cnt, 1024);
        chk("x first x", first_x, 64);
        chk("x first y", first_y, 32);
        chk("x last x", last_x, 95);
        chk("x last y", last_y, 63);
        chk("x done latency", done_n - m_k, 1024);
        chk("x (4,4)", int'(fb[68][36]), 4);
        chk("x (5,4)", int'(fb[69][36]), 0);
        chk("x (27,4)", int'(fb[91][36]), 4);

        clear_stats();
        start_draw(0, 0, 1);
        wait_done("o draw", 1200);
        bus.start = 1'b0;
        cyc(3);
        chk("o writes", wr_cnt, 1024);
        chk("o (4,4)", int'(fb[4][4]), 1);
        chk("o (16,4)", int'(fb[16][4]), 1);
        chk("o (27,16)", int'(fb[27][16]), 1);
        chk("o (16,16)", int'(fb[16][16]), 0);
        chk("o outside writes", oob_cnt, 0);
        chk("grid (0,7)", int'(fb[0][7]), grid_c);
        chk("grid (31,31)", int'(fb[31][31]), grid_c);

        clear_stats();
        start_draw(1, 1, 0);
        cyc(2000);
        chk("held done pulses", done_cnt, 1);
        chk("held writes", wr_cnt, 1024);
        chk("held busy in release", int'(bus.busy), 1);
        bus.start = 1'b0;
        cyc(3);
        chk("held busy after drop", int'(bus.busy), 0);
        clear_stats();
        bus.start = 1'b1;
        wait_done("redraw", 1200);
        bus.start = 1'b0;
        cyc(3);
        chk("redraw writes", wr_cnt, 1024);

        clear_stats();
        start_draw(2, 0, 1);
        i = 0;
        while (wr_cnt < 100 && i < 500) begin
            cyc(1);
            i++;
        end
        chk("abort writes before reset", wr_cnt, 100);
        #2;
        rst_n = 1'b0;
        bus.start = 1'b0;
        #1;
        chk("abort pixel_write", int'(bus.pixel_write), 0);
        chk("abort busy", int'(bus.busy), 0);
        cyc(2);
        chk("abort no done", done_cnt, 0);
        rst_n = 1'b1;
        cyc(2);
        clear_stats();
        start_draw(2, 1, 1);
        wait_done("after abort", 1200);
        bus.start = 1'b0;
        cyc(3);
        chk("after abort writes", wr_cnt, 1024);

        clear_stats();
        start_draw(3, 1, 0);
        wait_done("invalid", 10);
        chk("invalid done latency", done_n - m_k, 0);
        cyc(5);
        chk("invalid writes", wr_cnt, 0);
        chk("invalid busy in release", int'(bus.busy), 1);
        chk("invalid single done", done_cnt, 1);
        bus.start = 1'b0;
        cyc(2);
        chk("invalid busy after drop", int'(bus.busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cell_renderer.md
Name: cell_renderer

Overview:
- Drawing engine that answers the board input controller's enable_drawing / drawing_done handshake.
- On a start request it latches the target cell (row, col) and the player, then raster-scans that cell's CELL_SIZE x CELL_SIZE pixel square.
- It writes one pixel per cycle to the VGA framebuffer write port: symbol colour (X or O) or background.
- When the scan is finished it pulses drawing_done for one cycle.

Parameters:
- CELL_SIZE, 32, cell edge in pixels; must be a power of 2, at least 8.
- MARGIN, 4, inset in pixels between the cell edge and the symbol.
- GRID_X0, 0, screen x of the left edge of cell column 0.
- GRID_Y0, 0, screen y of the top edge of cell row 0.
- X_W, 10, width of pixel_x.
- Y_W, 9, width of pixel_y.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous reset, active-low.
- start  in  1  draw request, level (controller's enable_drawing).
- cell_row  in  2  target row, 0..2.
- cell_col  in  2  target column, 0..2.
- player  in  1  0 = X, 1 = O.
- pixel_x  out  X_W  framebuffer write x.
- pixel_y  out  Y_W  framebuffer write y.
- pixel_color  out  3  RGB 1-bit each.
- pixel_write  out  1  framebuffer write strobe.
- busy  out  1  high in every state except IDLE.
- drawing_done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: reset_n low forces IDLE immediately (asynchronous); a draw in progress is aborted.
  - All outputs are 0 during and after reset: pixel_write, drawing_done, busy, pixel_x/y/color.
  - Scan counters dx and dy are cleared; no drawing_done is issued for an aborted draw.
- States: IDLE, DRAW, DONE, RELEASE.
- IDLE:
  - start=1 latches cell_row, cell_col and player, clears dx and dy.
  - Goes to DRAW if row<=2 and col<=2, otherwise to DONE with zero writes.
  - Inputs are ignored outside IDLE.
- DRAW:
  - pixel_write=1 every cycle.
  - pixel_x = GRID_X0 + col*CELL_SIZE + dx; pixel_y = GRID_Y0 + row*CELL_SIZE + dy; both truncated to X_W/Y_W.
  - dx increments every cycle; when dx wraps from CELL_SIZE-1 to 0, dy increments.
  - At dx=dy=CELL_SIZE-1 (the CELL_SIZE^2-th write) the next state is DONE.
- Colour rule, with inner = dx and dy both in [MARGIN, CELL_SIZE-1-MARGIN]:
  - X (player 0): red 3'b100 when inner and (dx==dy or dx+dy==CELL_SIZE-1).
  - O (player 1): blue 3'b001 when inner and dx or dy equals MARGIN or CELL_SIZE-1-MARGIN (hollow box).
  - Every other pixel is background 3'b000.
- Outputs are registered. pixel_x, pixel_y, pixel_color and pixel_write change together and are valid in the same cycle.
- DONE: drawing_done=1 for exactly one cycle, pixel_write=0, then go to RELEASE.
- RELEASE: wait until start=0, then go to IDLE. A start held high never causes a second draw.
- Latency: start accepted at edge k gives pixel writes in cycles k+1 .. k+CELL_SIZE^2 and drawing_done in cycle k+CELL_SIZE^2+1.
- Invalid cell: drawing_done in cycle k+1.
- start is ignored in DRAW, DONE and RELEASE; latched row, col and player cannot change mid-draw.

Optional Feature:
- Macro: GRID_LINES_EN.
- Defined: pixels with dx==0, dy==0, dx==CELL_SIZE-1 or dy==CELL_SIZE-1 are drawn white 3'b111. This has priority over the symbol colour.
- Undefined: those pixels follow the normal colour rule (background).
- Timing and write count are identical with or without the macro.

Decomposition:
- Package draw_pkg holds:
  - the state enum (IDLE, DRAW, DONE, RELEASE);
  - colour constants COLOR_BG, COLOR_X, COLOR_O, COLOR_GRID;
  - the shared CELL_SIZE/MARGIN defaults.
- One sub-module, cell_pixel_shader: combinational, maps (dx, dy, player) to colour, and contains the GRID_LINES_EN branch.
- The scan FSM, counters and address arithmetic stay in cell_renderer.

Test Plan:
- Reset, then start=1 with row=1, col=2, player=0 (defaults) -> exactly 1024 writes.
  - First write (x=64, y=32), last write (x=95, y=63).
  - (dx,dy)=(4,4) red, (5,4) black, (27,4) red.
  - drawing_done is high in exactly one cycle, 1025 cycles after the accept edge.
- row=0, col=0, player=1 -> (4,4) blue, (16,4) blue, (27,16) blue, (16,16) black; no write outside x,y 0..31.
- start held high for 2000 cycles across completion -> a single draw and a single done pulse. Dropping start then raising it again -> a second full draw.
- reset_n low asynchronously after 100 writes -> pixel_write and busy go to 0 before the next edge, and there is no done pulse. After release, a new start gives a full 1024-write draw.
- row=3, col=1, start -> zero writes, drawing_done in cycle k+1, then RELEASE until start drops.
- Compiled with GRID_LINES_EN -> (dx,dy)=(0,7) and (31,31) are white. Without the macro the same pixels are black, and the write count is 1024 in both builds.
